// File: rtl/serial_mag_compare.sv
// Serial unsigned magnitude comparator: one 2-bit digit per clock, MSB digit first.
// Optional macro SERIAL_CMP_EARLY_EXIT_EN ends the scan at the first differing digit.
module serial_mag_compare #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             in1greater,
  output logic             in2greater,
  output logic             equal
);

  localparam int NDIG = WIDTH / 2;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

  state_t         state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IW-1:0]  idx_q;
  logic           gt_q, lt_q;

  logic [1:0] a_dig, b_dig;
  logic       new_gt, new_lt, done_now, accept;

  // Operands shift left each cycle, so the current digit is always the top two bits.
  assign a_dig  = a_q[WIDTH-1 -: 2];
  assign b_dig  = b_q[WIDTH-1 -: 2];
  assign accept = (state_q == IDLE) && in_valid;

  always_comb begin
    new_gt   = gt_q | (!(gt_q | lt_q) & (a_dig > b_dig));
    new_lt   = lt_q | (!(gt_q | lt_q) & (a_dig < b_dig));
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    done_now = (idx_q == '0) || new_gt || new_lt;
`else
    done_now = (idx_q == '0);
`endif
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = COMPARE;
      COMPARE: if (done_now)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      idx_q <= '0;
      gt_q  <= 1'b0;
      lt_q  <= 1'b0;
    end else if (accept) begin
      a_q   <= in1;
      b_q   <= in2;
      idx_q <= IW'(NDIG - 1);
      gt_q  <= 1'b0;
      lt_q  <= 1'b0;
    end else if (state_q == COMPARE) begin
      a_q   <= a_q << 2;
      b_q   <= b_q << 2;
      idx_q <= idx_q - IW'(1);
      gt_q  <= new_gt;
      lt_q  <= new_lt;
    end
  end

  // Outputs are registered from the next state so nothing combinational reaches a port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      in1greater <= 1'b0;
      in2greater <= 1'b0;
      equal      <= 1'b0;
    end else begin
      in_ready <= (state_d == IDLE);
      if (state_q == COMPARE && done_now) begin
        out_valid  <= 1'b1;
        in1greater <= new_gt;
        in2greater <= new_lt;
        equal      <= !new_gt && !new_lt;
      end else if (state_q == DONE && out_ready) begin
        out_valid  <= 1'b0;
        in1greater <= 1'b0;
        in2greater <= 1'b0;
        equal      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_mag_compare.sv
// Scoreboard bench for serial_mag_compare (WIDTH=8); honours SERIAL_CMP_EARLY_EXIT_EN.
module tb_serial_mag_compare;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         in1greater, in2greater, equal;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0] res;   // {in1greater, in2greater, equal}
    int         cyc;   // cycle of out_valid, accept cycle = 0
  } exp_t;
  exp_t sb[$];

  serial_mag_compare #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2),
    .out_valid(out_valid), .out_ready(out_ready),
    .in1greater(in1greater), .in2greater(in2greater), .equal(equal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.res = {a > b, a < b, a == b};
    e.cyc = W / 2 + 1;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    for (int d = W / 2 - 1; d >= 0; d--) begin
      if (a[2*d +: 2] != b[2*d +: 2]) begin
        e.cyc = (W / 2 - d) + 1;
        break;
      end
    end
`endif
    return e;
  endfunction

  task automatic txn(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    exp_t e;
    int cyc;
    out_ready = (hold == 0);
    @(negedge clk);
    check("ready_before", in_ready, 1);
    in_valid = 1'b1; in1 = a; in2 = b;
    sb.push_back(model(a, b));
    @(posedge clk); #1;
    in_valid = 1'b0; in1 = W'($urandom); in2 = W'($urandom);
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      in_valid = 1'($urandom);
      if (out_valid) break;
      check("busy_zero", {in_ready, in1greater, in2greater, equal}, 0);
      if (cyc > 20) begin
        check("timeout", 0, 1);
        in_valid = 1'b0;
        void'(sb.pop_front());
        return;
      end
    end
    e = sb.pop_front();
    check("latency", cyc, e.cyc);
    check("result", {in1greater, in2greater, equal}, e.res);
    check("ready_in_done", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_result", {in1greater, in2greater, equal}, e.res);
      check("hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_valid", {out_valid, in1greater, in2greater, equal}, 0);
    check("post_ready", in_ready, 1);
  endtask

  initial begin
    #12;
    check("rst_ready", in_ready, 1);
    check("rst_outs", {out_valid, in1greater, in2greater, equal}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    txn(8'hA5, 8'hA5, 0);
    txn(8'hC0, 8'h40, 0);
    txn(8'h12, 8'h13, 0);
    txn(8'h01, 8'h00, 3);
    txn(8'h00, 8'hFF, 0);
    txn(8'h7F, 8'h80, 1);
    for (int i = 0; i < 8; i++) txn(W'($urandom), W'($urandom), i % 3);

    // Reset mid-compare discards the transaction.
    @(negedge clk);
    in_valid = 1'b1; in1 = 8'hA5; in2 = 8'h00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", in_ready, 1);
    check("midrst_outs", {out_valid, in1greater, in2greater, equal}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("after_rst", {in_ready, out_valid, in1greater, in2greater, equal}, 5'b10000);
    end
    txn(8'hFF, 8'h00, 0);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_mag_compare.md
SERIAL_MAG_COMPARE -- requirements
Module: serial_mag_compare

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand width in bits; legal values are even and >= 2.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous assert and active-low.
REQ-004 The block SHALL have port in_valid  input  1  operand pair valid.
REQ-005 The block SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-006 The block SHALL have port in1  input  WIDTH  first operand, unsigned.
REQ-007 The block SHALL have port in2  input  WIDTH  second operand, unsigned.
REQ-008 The block SHALL have port out_valid  output  1  result valid.
REQ-009 The block SHALL have port out_ready  input  1  downstream accepts result.
REQ-010 The block SHALL have port in1greater  output  1  in1 > in2.
REQ-011 The block SHALL have port in2greater  output  1  in2 > in1.
REQ-012 The block SHALL have port equal  output  1  in1 == in2.

Function
REQ-013 The block SHALL compare in1 and in2 serially, one 2-bit digit per clock, MSB digit first (digit WIDTH/2-1 down to 0).
REQ-014 The FSM SHALL have states IDLE, COMPARE and DONE.
REQ-015 In IDLE, in_ready SHALL be 1; in COMPARE and DONE, in_ready SHALL be 0.
REQ-016 An operand pair SHALL be accepted on a rising edge where in_valid=1 and in_ready=1: in1/in2 are captured into internal registers, the digit index is loaded with WIDTH/2-1, and the FSM goes IDLE->COMPARE.
REQ-017 In COMPARE, each cycle SHALL compare the current 2-bit digit pair unsigned and decrement the digit index.
REQ-018 The first digit pair that differs SHALL decide the result; later digits SHALL NOT change it (sticky).
REQ-019 If all digit pairs are equal, the result SHALL be equal.
REQ-020 COMPARE->DONE SHALL occur after the digit-0 cycle, or earlier per REQ-030.
REQ-021 In DONE, out_valid SHALL be 1 and exactly one of in1greater, in2greater and equal SHALL be 1.
REQ-022 Whenever out_valid=0, in1greater, in2greater and equal SHALL all be 0.
REQ-023 All outputs SHALL be driven from registers; there SHALL be no combinational path from input ports to output ports.
REQ-024 Result and out_valid SHALL hold stable in DONE until a rising edge with out_ready=1, on which the FSM SHALL go DONE->IDLE.
REQ-025 in_ready SHALL rise the cycle after the result handshake, so there are no same-cycle back-to-back transactions.
REQ-026 Input changes while in COMPARE or DONE SHALL have no effect.
REQ-027 Latency SHALL be k+1 cycles from accept edge to out_valid, where k is the number of digits examined; WIDTH=8 full scan gives accept at cycle 0 and out_valid at cycle 5.

Reset
REQ-028 When rst_n=0, the block SHALL immediately force state=IDLE, in_ready=1, out_valid=0, all result outputs=0, and operand/index registers=0.
REQ-029 Reset asserted mid-COMPARE or in DONE SHALL discard the transaction with no result emitted; the first edge with rst_n=1 SHALL see in_ready=1.

Configuration
REQ-030 With macro SERIAL_CMP_EARLY_EXIT_EN defined, COMPARE->DONE SHALL occur on the cycle the first differing digit is found, so k is 1..WIDTH/2.
REQ-031 Without SERIAL_CMP_EARLY_EXIT_EN, COMPARE SHALL always last exactly WIDTH/2 cycles regardless of data (constant latency); result values are identical in both builds.

Verification
REQ-032 WIDTH=8, in1=8'hA5, in2=8'hA5, out_ready=1 -> equal=1 at cycle 5 (both builds), one cycle long; in_ready back at cycle 6.
REQ-033 in1=8'hC0, in2=8'h40 -> in1greater=1; out_valid at cycle 2 with EARLY_EXIT_EN, cycle 5 without.
REQ-034 in1=8'h12, in2=8'h13 (differ only in digit 0) -> in2greater=1 at cycle 5 in both builds.
REQ-035 in1=8'h01, in2=8'h00, out_ready=0 for 3 cycles after out_valid -> in1greater and out_valid hold steady, in_ready=0; release on out_ready=1, then IDLE.
REQ-036 Assert rst_n=0 at cycle 2 of a compare, then release -> out_valid never asserts, outputs 0, in_ready=1; a new pair 8'hFF vs 8'h00 then yields in1greater=1.
